pix_i2c_init_seq: RTL

- Table-driven command sequencer that sits directly upstream of the PIX I2C master.
- On `start`, walks an external init table (sensor register writes and timed waits) and drives the master's command port one entry at a time.
- Holds command fields stable until the master's `cmd_done` pulse; retries failed (NACK) transfers.
- Reports overall completion, status and the failing table index to the sensor-control logic.

---
 rtl/pix_i2c_pkg.sv | 48 ++++
 rtl/pix_us_timer.sv | 49 ++++
 rtl/pix_i2c_init_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pix_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pix_i2c_pkg
// Purpose  : Shared constants for the PIX I2C init sequencer: table-entry
//            field positions, op encodings, transfer lengths, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package pix_i2c_pkg;

    // Width of the microsecond down-counter (matches the 16-bit data field)
    localparam int c_us_w = 16;

    // Table entry layout: [35:34] op, [33:32] len, [31:16] regAddr, [15:0] data/us
    localparam int c_op_msb  = 35;
    localparam int c_op_lsb  = 34;
    localparam int c_len_msb = 33;
    localparam int c_len_lsb = 32;
    localparam int c_reg_msb = 31;
    localparam int c_reg_lsb = 16;
    localparam int c_dat_msb = 15;
    localparam int c_dat_lsb = 0;

    // Op encodings
    localparam logic [1:0] c_op_write = 2'd0;
    localparam logic [1:0] c_op_delay = 2'd1;
    localparam logic [1:0] c_op_end   = 2'd2;
    localparam logic [1:0] c_op_rsvd  = 2'd3;

    // Master transfer length; zero means "no request"
    localparam logic [1:0] c_len_none = 2'd0;
    localparam logic [1:0] c_len_one  = 2'd1;
    localparam logic [1:0] c_len_two  = 2'd2;

    // Sequencer states
    localparam int         c_st_w      = 4;
    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_fetch  = 4'd1;
    localparam logic [3:0] c_st_decode = 4'd2;
    localparam logic [3:0] c_st_issue  = 4'd3;
    localparam logic [3:0] c_st_wait   = 4'd4;
    localparam logic [3:0] c_st_gap    = 4'd5;
    localparam logic [3:0] c_st_delay  = 4'd6;
    localparam logic [3:0] c_st_finish = 4'd7;
    localparam logic [3:0] c_st_vread  = 4'd8;
    localparam logic [3:0] c_st_vwait  = 4'd9;

endpackage
`default_nettype wire

// File: rtl/pix_us_timer.sv
`default_nettype none
// ============================================================================
// Module   : pix_us_timer
// Purpose  : 1 us prescaler plus 16-bit microsecond down-counter. A load
//            restarts the prescaler, so a wait of N us lasts N*(CLK_FREQ/1e6)
//            cycles. expired is high whenever the counter is zero.
// Revision : 1.0 - initial release
// ============================================================================
module pix_us_timer
    import pix_i2c_pkg::*;
#(
    parameter int CLK_FREQ = 12000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [c_us_w-1:0] load_us,
    output logic              expired
);

    localparam int          c_div_raw = CLK_FREQ / 1000000;
    localparam int          c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam logic [15:0] c_pre_top = 16'(c_div - 1);

    logic [15:0]       r_pre;
    logic [c_us_w-1:0] r_us;

    // Prescaler divides clk to 1 us ticks; each tick decrements the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_us  <= '0;
        end else if (load) begin
            r_pre <= '0;
            r_us  <= load_us;
        end else if (r_us != '0) begin
            if (r_pre == c_pre_top) begin
                r_pre <= '0;
                r_us  <= r_us - 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign expired = (r_us == '0);

endmodule
`default_nettype wire

// File: rtl/pix_i2c_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : pix_i2c_init_seq
// Purpose  : Table-driven command sequencer feeding the PIX I2C master.
//            Walks an init table of register writes / waits / end markers,
//            retries NACKed transfers after a fixed gap, and reports status.
//            Optional build macro PIX_I2C_INIT_SEQ_VERIFY_EN adds a read-back
//            check after every successful write.
// Revision : 1.0 - initial release
// ============================================================================
module pix_i2c_init_seq
    import pix_i2c_pkg::*;
#(
    parameter int         CLK_FREQ     = 12000000,
    parameter logic [6:0] SLAVE_ADDR   = 7'h10,
    parameter int         TABLE_DEPTH  = 64,
    parameter int         MAX_RETRIES  = 3,
    parameter int         RETRY_GAP_US = 100
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           ok,
    output logic [$clog2(TABLE_DEPTH)-1:0] fail_index,
    output logic [$clog2(TABLE_DEPTH)-1:0] tbl_addr,
    input  logic [35:0]                    tbl_data,
    output logic [6:0]                     cmd_slaveAddr,
    output logic                           cmd_write,
    output logic [15:0]                    cmd_regAddr,
    output logic [15:0]                    cmd_writeData,
    input  logic [15:0]                    cmd_readData,
    output logic [1:0]                     cmd_dataLen,
    input  logic                           cmd_done,
    input  logic                           cmd_ok
);

    localparam int                c_aw          = $clog2(TABLE_DEPTH);
    localparam logic [c_aw-1:0]   c_last_addr   = c_aw'(TABLE_DEPTH - 1);
    localparam logic [7:0]        c_max_retries = 8'(MAX_RETRIES);
    localparam logic [c_us_w-1:0] c_gap_us      = c_us_w'(RETRY_GAP_US);

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_next;
    logic [7:0]        r_retries;

    // Entry fields as seen in DECODE
    logic [1:0]  w_op;
    logic [1:0]  w_len;
    logic [15:0] w_reg;
    logic [15:0] w_dat;
    logic        w_len_bad;
    logic        w_last;

    // Control strobes decoded from state and inputs
    logic              w_accept;
    logic              w_load_cmd;
    logic              w_load_read;
    logic              w_dec_end;
    logic              w_dec_bad;
    logic              w_xfer_done;
    logic              w_xfer_pass;
    logic              w_entry_ok;
    logic              w_att_fail;
    logic              w_retry;
    logic              w_give_up;
    logic              w_tmr_load;
    logic [c_us_w-1:0] w_tmr_val;
    logic              w_tmr_expired;

    assign w_op      = tbl_data[c_op_msb:c_op_lsb];
    assign w_len     = tbl_data[c_len_msb:c_len_lsb];
    assign w_reg     = tbl_data[c_reg_msb:c_reg_lsb];
    assign w_dat     = tbl_data[c_dat_msb:c_dat_lsb];
    assign w_len_bad = (w_len != c_len_one) && (w_len != c_len_two);
    assign w_last    = (tbl_addr == c_last_addr);
    assign w_accept  = (r_state == c_st_idle) && start;

    assign cmd_slaveAddr = SLAVE_ADDR;

`ifdef PIX_I2C_INIT_SEQ_VERIFY_EN
    // Length of the entry being verified; a 1-byte write only compares the low byte
    logic [1:0] r_len;
    logic       w_rd_match;
    assign w_rd_match = (r_len == c_len_one) ? (cmd_readData[7:0] == cmd_writeData[7:0])
                                             : (cmd_readData == cmd_writeData);
`else
    logic w_unused_rd;
    assign w_unused_rd = ^cmd_readData;
`endif

    pix_us_timer #(
        .CLK_FREQ (CLK_FREQ)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_tmr_load),
        .load_us (w_tmr_val),
        .expired (w_tmr_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Output decode: per-state strobes driving the datapath and the timer
    always_comb begin
        w_load_cmd  = 1'b0;
        w_load_read = 1'b0;
        w_dec_end   = 1'b0;
        w_dec_bad   = 1'b0;
        w_xfer_done = 1'b0;
        w_xfer_pass = 1'b0;
        w_entry_ok  = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = w_dat;
        case (r_state)
            c_st_decode: begin
                case (w_op)
                    c_op_write: begin
                        w_load_cmd = !w_len_bad;
                        w_dec_bad  = w_len_bad;
                    end
                    c_op_delay: w_tmr_load = 1'b1;
                    c_op_end:   w_dec_end  = 1'b1;
                    c_op_rsvd:  w_dec_bad  = 1'b1;
                    default:    w_dec_bad  = 1'b1;
                endcase
            end
            c_st_wait: begin
                w_xfer_done = cmd_done;
                w_xfer_pass = cmd_ok;
`ifndef PIX_I2C_INIT_SEQ_VERIFY_EN
                w_entry_ok  = cmd_done && cmd_ok;
`endif
            end
`ifdef PIX_I2C_INIT_SEQ_VERIFY_EN
            c_st_vread: w_load_read = 1'b1;
            c_st_vwait: begin
                w_xfer_done = cmd_done;
                w_xfer_pass = cmd_ok && w_rd_match;
                w_entry_ok  = cmd_done && cmd_ok && w_rd_match;
            end
`endif
            c_st_delay: w_entry_ok = w_tmr_expired;
            default: ;
        endcase
        w_att_fail = w_xfer_done && !w_xfer_pass;
        w_retry    = w_att_fail && (r_retries < c_max_retries);
        w_give_up  = w_att_fail && !w_retry;
        if (w_retry) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = c_gap_us;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:   if (start) w_next = c_st_fetch;
            c_st_fetch:  w_next = c_st_decode;
            c_st_decode: begin
                if (w_load_cmd)      w_next = c_st_issue;
                else if (w_tmr_load) w_next = c_st_delay;
                else                 w_next = c_st_finish;
            end
            c_st_issue:  w_next = c_st_wait;
            c_st_wait, c_st_vwait, c_st_delay: begin
                if (w_retry)         w_next = c_st_gap;
                else if (w_give_up)  w_next = c_st_finish;
                else if (w_entry_ok) w_next = w_last ? c_st_finish : c_st_fetch;
`ifdef PIX_I2C_INIT_SEQ_VERIFY_EN
                else if (w_xfer_done) w_next = c_st_vread;
`endif
            end
`ifdef PIX_I2C_INIT_SEQ_VERIFY_EN
            c_st_vread:  w_next = c_st_vwait;
`else
            c_st_vread:  w_next = c_st_idle;
`endif
            c_st_gap:    if (w_tmr_expired) w_next = c_st_fetch;
            c_st_finish: w_next = c_st_idle;
            default:     w_next = c_st_idle;
        endcase
    end

    // Datapath: table pointer, retry count, status and master command fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            ok            <= 1'b0;
            fail_index    <= '0;
            tbl_addr      <= '0;
            r_retries     <= '0;
            cmd_write     <= 1'b0;
            cmd_regAddr   <= '0;
            cmd_writeData <= '0;
            cmd_dataLen   <= c_len_none;
`ifdef PIX_I2C_INIT_SEQ_VERIFY_EN
            r_len         <= c_len_none;
`endif
        end else begin
            done <= (w_next == c_st_finish);
            if (w_next == c_st_finish) busy <= 1'b0;
            if (w_accept) begin
                tbl_addr  <= '0;
                busy      <= 1'b1;
                ok        <= 1'b0;
                r_retries <= '0;
            end
            if (w_load_cmd) begin
                cmd_regAddr   <= w_reg;
                cmd_writeData <= w_dat;
                cmd_write     <= 1'b1;
                cmd_dataLen   <= w_len;
`ifdef PIX_I2C_INIT_SEQ_VERIFY_EN
                r_len         <= w_len;
`endif
            end
`ifdef PIX_I2C_INIT_SEQ_VERIFY_EN
            if (w_load_read) begin
                cmd_write   <= 1'b0;
                cmd_dataLen <= r_len;
            end
`endif
            if (w_xfer_done) cmd_dataLen <= c_len_none;
            if (w_entry_ok) begin
                r_retries <= '0;
                if (w_last) ok <= 1'b1;
                else        tbl_addr <= tbl_addr + 1'b1;
            end
            if (w_dec_end) ok <= 1'b1;
            if (w_dec_bad || w_give_up) begin
                ok         <= 1'b0;
                fail_index <= tbl_addr;
            end
            if (w_retry) r_retries <= r_retries + 1'b1;
        end
    end

endmodule
`default_nettype wire
